// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_pkg
//  Purpose  : Shared UART definitions used by uart_tx and uart_rx: frame data
//             width, FSM state encoding and the clocks-per-bit helper.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  // Integer division: any fractional remainder is dropped, matching uart_tx.
  function automatic int clks_per_bit(input int input_clk, input int baud_rate);
    return input_clk / baud_rate;
  endfunction

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_sync.sv
`default_nettype none
// ============================================================================
//  Module   : uart_sync
//  Purpose  : Two-flop synchroniser for a single asynchronous input bit.
//  Ports    : clk      in  1  sampling clock
//             reset    in  1  synchronous active-high reset
//             d_i      in  1  asynchronous input
//             q_o      out 1  synchronised output (2 cycles latency)
//  Params   : RESET_VAL  value both flops take in reset (idle level of d_i)
//  Revision : 1.0  initial release
// ============================================================================
module uart_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule : uart_sync
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx
//  Purpose  : 8N1 UART receiver. Synchronises the serial line, detects the
//             falling edge of the start bit, samples each bit at its centre
//             and presents the received byte with a one-cycle valid pulse.
//  Ports    : clk        in  1  sole clock, rising edge
//             reset      in  1  synchronous active-high reset
//             rx         in  1  asynchronous serial input, idles high
//             rx_data    out 8  last good byte, held until the next good frame
//             rx_valid   out 1  one-cycle pulse when rx_data updates
//             frame_err  out 1  one-cycle pulse when the stop bit is low
//             rx_busy    out 1  high while a frame is in progress
//  Params   : INPUT_CLK  clock frequency in Hz
//             BAUD_RATE  line rate in bit/s
//  Revision : 1.0  initial release
// ============================================================================
module uart_rx
  import uart_pkg::*;
#(
  parameter int INPUT_CLK = 100_000_000,
  parameter int BAUD_RATE = 115_200
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 rx_busy
);

  localparam int N     = clks_per_bit(INPUT_CLK, BAUD_RATE);
  localparam int H     = N / 2;
  localparam int CNT_W = $clog2(N);
  localparam int IDX_W = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(H - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  // Too few clocks per bit leaves no room for a centred sample point.
  generate
    if (N < 4) begin : g_bad_clk_ratio
      $error("uart_rx: INPUT_CLK/BAUD_RATE must be at least 4");
    end
  endgenerate

  logic                 rx_s;
  logic                 prev_q;
  uart_state_e          state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [IDX_W-1:0]     idx_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 start_det;

  uart_sync #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (rx),
    .q_o   (rx_s)
  );

  // Falling edge only: a line parked low cannot start a second frame.
  assign start_det = ~rx_s & prev_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= '0;
      prev_q    <= 1'b1;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      prev_q    <= rx_s;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      cnt_q     <= cnt_q + CNT_W'(1);

      case (state_q)
        IDLE: begin
          if (start_det) begin
            state_q <= START;
            cnt_q   <= '0;
          end
        end

        START: begin
          // Re-check the line at mid start bit to reject short glitches.
          if (cnt_q == CNT_HALF) begin
            cnt_q <= '0;
            if (!rx_s) begin
              state_q <= DATA;
              idx_q   <= '0;
            end else begin
              state_q <= IDLE;
            end
          end
        end

        DATA: begin
          // Counter restarts per bit so each sample stays one bit period
          // after the previous one, mid-bit.
          if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
            idx_q   <= idx_q + IDX_W'(1);
            if (idx_q == IDX_LAST) begin
              state_q <= STOP;
            end
          end
        end

        STOP: begin
          // Leaving at mid stop bit lets a back-to-back start edge be seen.
          if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            state_q <= IDLE;
            if (rx_s) begin
              rx_data  <= shift_q;
              rx_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end
        end

        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign rx_busy = (state_q != IDLE);

endmodule : uart_rx
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx
//  Purpose  : Self-checking bench for uart_rx at INPUT_CLK=21, BAUD_RATE=4
//             (5 clocks per bit). Frames are bit-banged onto rx; expected
//             outputs are queued when a frame is driven and compared by a
//             monitor when rx_valid or frame_err pulses.
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_rx;

  localparam int INPUT_CLK = 21;
  localparam int BAUD_RATE = 4;
  localparam int N         = INPUT_CLK / BAUD_RATE;
  localparam int H         = N / 2;
  localparam int STOP_LAT  = 2 + H + 9 * N;

  typedef struct packed {
    logic       err;
    logic [7:0] data;
  } exp_t;

  logic       clk;
  logic       reset;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       rx_busy;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   n_valid  = 0;
  int   n_err    = 0;
  int   last_valid_cyc = -1;
  logic [7:0] last_good = 8'h00;
  exp_t exp_q[$];

  uart_rx #(
    .INPUT_CLK (INPUT_CLK),
    .BAUD_RATE (BAUD_RATE)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .rx_busy   (rx_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: every pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rx_valid || frame_err) begin
      checks++;
      if (rx_valid && frame_err) begin
        failures++;
        $display("FAIL pulse_exclusive: rx_valid=1 frame_err=1 at cycle %0d, required never both", cyc);
      end else if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pulse: valid=%0b err=%0b data=%02h at cycle %0d, required no pulse",
                 rx_valid, frame_err, rx_data, cyc);
      end else begin
        e = exp_q.pop_front();
        if ({frame_err, rx_data} !== {e.err, e.data}) begin
          failures++;
          $display("FAIL scoreboard: got err=%0b data=%02h, required err=%0b data=%02h",
                   frame_err, rx_data, e.err, e.data);
        end
      end
      if (rx_valid) begin
        n_valid++;
        last_valid_cyc = cyc;
      end
      if (frame_err) n_err++;
    end
  end

  // Drive one frame starting at a negedge; c0 is the cycle index of E0.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit,
                            input int idle_after, output int c0);
    c0 = cyc + 1;
    rx = 1'b0;
    repeat (N) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (N) @(negedge clk);
    end
    rx = stop_bit;
    repeat (N) @(negedge clk);
    rx = 1'b1;
    repeat (idle_after) @(negedge clk);
  endtask

  task automatic expect_byte(input logic [7:0] d);
    exp_q.push_back('{err: 1'b0, data: d});
    last_good = d;
  endtask

  task automatic expect_ferr();
    exp_q.push_back('{err: 1'b1, data: last_good});
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_drained: %0d expected pulses missing, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({rx_data, rx_valid, frame_err, rx_busy} !== 11'd0) begin
      failures++;
      $display("FAIL reset_in: data=%02h v=%0b e=%0b busy=%0b, required all 0",
               rx_data, rx_valid, frame_err, rx_busy);
    end
    reset = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if ({rx_data, rx_valid, frame_err, rx_busy} !== 11'd0) begin
      failures++;
      $display("FAIL reset_idle: data=%02h v=%0b e=%0b busy=%0b, required all 0",
               rx_data, rx_valid, frame_err, rx_busy);
    end
  endtask

  task automatic test_loopback();
    logic [7:0] bytes [4];
    int c0;
    int c_first;
    int nv0;
    bytes[0] = 8'h35; bytes[1] = 8'hC3; bytes[2] = 8'hAA; bytes[3] = 8'h55;
    nv0 = n_valid;
    c_first = 0;
    for (int i = 0; i < 4; i++) begin
      expect_byte(bytes[i]);
      send_frame(bytes[i], 1'b1, 2 * N, c0);
      if (i == 0) begin
        c_first = c0;
        checks++;
        if (last_valid_cyc != c_first + STOP_LAT) begin
          failures++;
          $display("FAIL loopback_latency: first rx_valid at E%0d, required E%0d",
                   last_valid_cyc - c_first, STOP_LAT);
        end
      end
    end
    checks++;
    if (n_valid - nv0 != 4) begin
      failures++;
      $display("FAIL loopback_count: %0d rx_valid pulses, required 4", n_valid - nv0);
    end
    checks++;
    if (rx_data !== 8'h55) begin
      failures++;
      $display("FAIL loopback_hold: rx_data=%02h, required 55", rx_data);
    end
    check_drained("loopback");
  endtask

  task automatic test_glitch();
    int busy_cnt;
    busy_cnt = 0;
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rx_busy) busy_cnt++;
    end
    checks++;
    if (busy_cnt < 1 || busy_cnt > H + 1) begin
      failures++;
      $display("FAIL glitch_busy: rx_busy high %0d cycles, required 1..%0d", busy_cnt, H + 1);
    end
    checks++;
    if (rx_busy !== 1'b0) begin
      failures++;
      $display("FAIL glitch_idle: rx_busy=%0b, required 0", rx_busy);
    end
    check_drained("glitch");
  endtask

  task automatic test_frame_err();
    int c0;
    int nv0;
    int ne0;
    nv0 = n_valid;
    ne0 = n_err;
    expect_ferr();
    send_frame(8'hF0, 1'b0, 2 * N, c0);
    checks++;
    if (n_err - ne0 != 1 || n_valid != nv0) begin
      failures++;
      $display("FAIL ferr_count: frame_err=%0d rx_valid=%0d, required 1 and 0",
               n_err - ne0, n_valid - nv0);
    end
    checks++;
    if (rx_data !== 8'h55) begin
      failures++;
      $display("FAIL ferr_hold: rx_data=%02h, required 55", rx_data);
    end
    check_drained("ferr");
  endtask

  task automatic test_break();
    int c0;
    int ne0;
    ne0 = n_err;
    expect_ferr();
    rx = 1'b0;
    repeat (30 * N) @(negedge clk);
    checks++;
    if (n_err - ne0 != 1 || rx_busy !== 1'b0) begin
      failures++;
      $display("FAIL break_single: frame_err=%0d busy=%0b, required 1 and 0",
               n_err - ne0, rx_busy);
    end
    rx = 1'b1;
    repeat (2 * N) @(negedge clk);
    expect_byte(8'h81);
    send_frame(8'h81, 1'b1, 2 * N, c0);
    checks++;
    if (rx_data !== 8'h81) begin
      failures++;
      $display("FAIL break_recover: rx_data=%02h, required 81", rx_data);
    end
    check_drained("break");
  endtask

  task automatic test_back_to_back();
    int c0;
    int nv0;
    nv0 = n_valid;
    expect_byte(8'h00);
    expect_byte(8'hFF);
    send_frame(8'h00, 1'b1, 0, c0);
    send_frame(8'hFF, 1'b1, 2 * N, c0);
    checks++;
    if (n_valid - nv0 != 2) begin
      failures++;
      $display("FAIL b2b_count: %0d rx_valid pulses, required 2", n_valid - nv0);
    end
    check_drained("b2b");
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] d;
    int c0;
    int nv0;
    int ne0;
    d   = 8'hF8;  // bits 3..7 high: line stays high once the frame is aborted
    nv0 = n_valid;
    ne0 = n_err;
    rx = 1'b0;
    repeat (N) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx = d[i];
      repeat (N) @(negedge clk);
    end
    rx = d[3];
    repeat (2) @(negedge clk);
    checks++;
    if (rx_busy !== 1'b1) begin
      failures++;
      $display("FAIL midrst_busy_before: rx_busy=%0b, required 1", rx_busy);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({rx_data, rx_valid, frame_err, rx_busy} !== 11'd0) begin
      failures++;
      $display("FAIL midrst_outputs: data=%02h v=%0b e=%0b busy=%0b, required all 0",
               rx_data, rx_valid, frame_err, rx_busy);
    end
    last_good = 8'h00;
    repeat (N - 3) @(negedge clk);
    for (int i = 4; i < 8; i++) begin
      rx = d[i];
      repeat (N) @(negedge clk);
    end
    rx = 1'b1;
    repeat (3 * N) @(negedge clk);
    checks++;
    if (n_valid != nv0 || n_err != ne0 || rx_busy !== 1'b0) begin
      failures++;
      $display("FAIL midrst_no_pulse: valid=%0d err=%0d busy=%0b, required 0 0 0",
               n_valid - nv0, n_err - ne0, rx_busy);
    end
    expect_byte(8'h5A);
    send_frame(8'h5A, 1'b1, 2 * N, c0);
    checks++;
    if (rx_data !== 8'h5A) begin
      failures++;
      $display("FAIL midrst_next: rx_data=%02h, required 5A", rx_data);
    end
    check_drained("midrst");
  endtask

  initial begin
    reset = 1'b1;
    rx    = 1'b1;
    @(negedge clk);
    test_reset();
    test_loopback();
    test_glitch();
    test_frame_err();
    test_break();
    test_back_to_back();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_uart_rx
`default_nettype wire
